router_pkt_src: RTL and testbench
=================================

# router_pkt_src

Packet source for the 3-port router. Sits directly upstream of the router input: a host loads payload words into a local buffer and issues a send command. The block then serialises header, payload and parity onto the router's `pkt_valid`/`data_in` pins. It stalls on router `busy`, so no word is ever lost or duplicated.

## Interface
Parameters:
- `DW`, 3: word width; matches router `data_in`.
- `DEPTH`, 16: payload buffer entries; maximum payload words per packet.
- `CW`, 5: counter width, `$clog2(DEPTH)+1`.

Ports:
- `clock`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `wr_en`, in, 1: append `wr_data` to payload buffer.
- `wr_data`, in, DW: payload word.
- `send`, in, 1: start packet (level sampled each cycle).
- `dest`, in, 2: destination port 0..2, sampled with `send`.
- `busy`, in, 1: router busy; stall when 1.
- `pkt_valid`, out, 1: to router `pkt_valid`.
- `data_out`, out, DW: to router `data_in`.
- `active`, out, 1: packet in progress (state ≠ IDLE).
- `wr_full`, out, 1: buffer holds DEPTH words.
- `word_cnt`, out, CW: words currently buffered.
- `done`, out, 1: one-cycle pulse, packet fully handed over.
- `reject`, out, 1: one-cycle pulse, send refused.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, DONE. Reset state is IDLE.
- **IDLE:**
  - `wr_en`=1 and `word_cnt`<DEPTH and `send`=0: `buf[word_cnt]`←`wr_data`, `word_cnt`+1.
  - `wr_en` is ignored when the buffer is full or when `send`=1. Send has priority over write.
  - `send`=1 with `word_cnt`≥1 and `dest`≤2: latch `dest` and the length, go to HEADER, clear read pointer, seed parity with the header.
  - `send`=1 with `word_cnt`=0 or `dest`=3: `reject`=1 next cycle, stay IDLE, buffer untouched.
- **HEADER:** drive `pkt_valid`=1, `data_out`={1'b0,dest}. If `busy`=0, go to PAYLOAD. If `busy`=1, hold.
- **PAYLOAD:** drive `pkt_valid`=1, `data_out`=`buf[rd_ptr]`.
  - On each cycle with `busy`=0: parity ^= word, `rd_ptr`+1.
  - After the last word (`rd_ptr`=len-1) with `busy`=0, go to PARITY.
- **PARITY:** drive `pkt_valid`=0, `data_out`=parity (XOR of header and all payload words). If `busy`=0, go to DONE.
- **DONE:** `pkt_valid`=0, `data_out`=0, `done`=1 for exactly one cycle. `word_cnt` is cleared and the FSM returns to IDLE.
- While not IDLE, `wr_en` and `send` are ignored and produce no `reject`.
- Outputs are registered. `data_out`=0 in IDLE and DONE.
- `active` = (state ≠ IDLE).
- `wr_full` = (`word_cnt`==DEPTH).

## Timing
- Reset values: `pkt_valid`=0, `data_out`=0, `active`=0, `wr_full`=0, `word_cnt`=0, `done`=0, `reject`=0. Buffer contents are don't-care.
- `send` sampled at edge T with `busy` held 0 for a packet of n words:
  - header valid in cycle T+1;
  - payload in cycles T+2..T+1+n;
  - parity in cycle T+2+n;
  - `done` in cycle T+3+n.
- Each `busy`=1 cycle in HEADER/PAYLOAD/PARITY adds exactly one cycle. Outputs must remain bit-identical while stalled.
- `busy` is combinationally consumed only for the next-state decision. There is no combinational path from `busy` to any output.
- Back-to-back packets: minimum gap is the DONE cycle plus the IDLE cycle needed to accept `send`. `pkt_valid` is low for at least 2 cycles between packets (PARITY + DONE).
- Reset asserted mid-packet: `pkt_valid` and `data_out` drop to 0 asynchronously. The buffer is emptied and no `done` is produced.
- `reject`/`done` never assert in the same cycle.

## Test plan
- **Basic packet.** Write 3,5,6, then `send` with `dest`=1, `busy`=0.
  - Expect `pkt_valid`=1 with `data_out` 001, 011, 101, 110 on consecutive cycles.
  - Then `pkt_valid`=0 with parity 001.
  - `done` one cycle later; `word_cnt`=0.
- **Stall.** Same packet with `busy`=1 for 2 cycles during the second payload word.
  - Word 101 is held 3 cycles.
  - Parity is still 001.
  - Total packet is 2 cycles longer.
- **Full buffer.** Write 17 words.
  - `wr_full`=1 after the 16th; the 17th is dropped.
  - Send with `dest`=2 gives 16 payload words, and parity equals the XOR of header 010 and all 16 words.
- **Rejects.** `send` with empty buffer gives `reject` pulse. `send` with `dest`=3 and 2 words buffered gives `reject`, and `word_cnt` stays 2. In both cases `pkt_valid` never rises.
- **Ignored inputs.**
  - `wr_en` and `send` both high in IDLE with 1 word buffered: packet starts, the write is discarded, and the payload is that 1 word.
  - `wr_en`/`send` pulsed during PAYLOAD: no effect on the packet or the count.
- **Reset mid-packet.** Assert `reset` during PAYLOAD word 2.
  - All outputs are 0 immediately.
  - After release: `word_cnt`=0, no `done`, and a new packet sends correctly.

Source files
------------

// File: rtl/router_pkt_src.sv
// router_pkt_src
//
// Packet source sitting directly in front of a 3-port router input. A host
// fills a small payload buffer word by word, then issues a send command. The
// block serialises header, payload and parity onto the router's
// pkt_valid/data_out pins. While the router reports busy, every output holds
// its value, so no word is lost or duplicated.
//
// Ports:
//   clock      - single clock, all state on the rising edge
//   reset      - asynchronous, active-high; clears all state immediately
//   wr_en      - append wr_data to the payload buffer (IDLE only)
//   wr_data    - payload word
//   send       - start a packet (level, sampled every cycle in IDLE)
//   dest       - destination port 0..2, sampled together with send
//   busy       - router busy; stalls the packet while high
//   pkt_valid  - to router pkt_valid (high for header and payload)
//   data_out   - to router data_in (header, payload, parity, else 0)
//   active     - a packet is in progress (state is not IDLE)
//   wr_full    - buffer holds DEPTH words
//   word_cnt   - number of words currently buffered
//   done       - one-cycle pulse once the packet is fully handed over
//   reject     - one-cycle pulse when a send is refused
module router_pkt_src #(
  parameter int DW    = 3,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          send,
  input  logic [1:0]    dest,
  input  logic          busy,
  output logic          pkt_valid,
  output logic [DW-1:0] data_out,
  output logic          active,
  output logic          wr_full,
  output logic [CW-1:0] word_cnt,
  output logic          done,
  output logic          reject
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] parity_q, parity_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          done_q, done_d;
  logic          reject_q, reject_d;
  logic          wr_full_q, wr_full_d;

  // Payload buffer. No reset: contents are only meaningful below word_cnt.
  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic          mem_rd;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] hdr_word;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    parity_d    = parity_q;
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    done_d      = 1'b0;
    reject_d    = 1'b0;
    mem_we      = 1'b0;
    mem_rd      = 1'b0;
    mem_raddr   = rd_ptr_q;
    hdr_word      = '0;
    hdr_word[1:0] = dest;

    unique case (state_q)
      S_IDLE: begin
        pkt_valid_d = 1'b0;
        data_out_d  = '0;
        // send wins over a simultaneous write; the write is discarded.
        if (send) begin
          if ((word_cnt_q != '0) && (dest != 2'd3)) begin
            state_d     = S_HEADER;
            len_d       = word_cnt_q;
            rd_ptr_d    = '0;
            parity_d    = hdr_word;
            pkt_valid_d = 1'b1;
            data_out_d  = hdr_word;
          end else begin
            reject_d = 1'b1;
          end
        end else if (wr_en && (word_cnt_q < CW'(DEPTH))) begin
          mem_we     = 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end

      S_HEADER: begin
        if (!busy) begin
          // Header accepted: fetch the first payload word into data_out.
          state_d   = S_PAYLOAD;
          mem_rd    = 1'b1;
          mem_raddr = rd_ptr_q;
        end
      end

      S_PAYLOAD: begin
        if (!busy) begin
          // data_out_q always holds mem[rd_ptr] here, so the word being
          // handed over is folded into the parity without a second read.
          parity_d = parity_q ^ data_out_q;
          if (CW'(rd_ptr_q) == (len_q - CW'(1))) begin
            state_d     = S_PARITY;
            pkt_valid_d = 1'b0;
            data_out_d  = parity_q ^ data_out_q;
          end else begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            mem_rd    = 1'b1;
            mem_raddr = rd_ptr_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (!busy) begin
          state_d     = S_DONE;
          pkt_valid_d = 1'b0;
          data_out_d  = '0;
          done_d      = 1'b1;
          word_cnt_d  = '0;
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        pkt_valid_d = 1'b0;
        data_out_d  = '0;
      end

      default: begin
        state_d     = S_IDLE;
        pkt_valid_d = 1'b0;
        data_out_d  = '0;
      end
    endcase

    wr_full_d = (word_cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      parity_q    <= '0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= '0;
      done_q      <= 1'b0;
      reject_q    <= 1'b0;
      wr_full_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      parity_q    <= parity_d;
      pkt_valid_q <= pkt_valid_d;
      done_q      <= done_d;
      reject_q    <= reject_d;
      wr_full_q   <= wr_full_d;
      // Registered buffer read lands directly in the output register.
      if (mem_rd) begin
        data_out_q <= mem_q[mem_raddr];
      end else begin
        data_out_q <= data_out_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[word_cnt_q[AW-1:0]] <= wr_data;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign active    = (state_q != S_IDLE);
  assign wr_full   = wr_full_q;
  assign word_cnt  = word_cnt_q;
  assign done      = done_q;
  assign reject    = reject_q;

endmodule

// File: tb/tb_router_pkt_src.sv
module tb_router_pkt_src;

  localparam int K_WORD = 0;
  localparam int K_PAR  = 1;
  localparam int K_DONE = 2;
  localparam int K_REJ  = 3;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_data;
  logic       send;
  logic [1:0] dest;
  logic       busy;
  logic       pkt_valid;
  logic [2:0] data_out;
  logic       active;
  logic       wr_full;
  logic [4:0] word_cnt;
  logic       done;
  logic       reject;

  router_pkt_src #(.DW(3), .DEPTH(16), .CW(5)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .send(send), .dest(dest), .busy(busy), .pkt_valid(pkt_valid),
    .data_out(data_out), .active(active), .wr_full(wr_full),
    .word_cnt(word_cnt), .done(done), .reject(reject)
  );

  typedef struct {
    int         kind;
    logic [2:0] val;
  } item_t;

  typedef struct {
    int         n_wr;
    logic [2:0] w [17];
    logic [1:0] dest;
    int         stall_at;
    int         stall_len;
    bit         poke;
    bit         wr_with_send;
    int         exp_par;
    bit         exp_rej;
  } vec_t;

  item_t      sb [$];
  logic [2:0] mbuf [$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int handed   = 0;
  int exp_done_cyc = 0;
  bit mon_en   = 0;
  bit hold_chk = 0;
  logic       hold_pv;
  logic [2:0] hold_do;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic observe(input int kind, input logic [2:0] val);
    item_t it;
    if (sb.size() == 0) begin
      chk(1'b0, "unexpected_event", kind * 8 + int'(val), -1);
      return;
    end
    it = sb.pop_front();
    chk((it.kind == kind) && (kind >= K_DONE || it.val == val), "sb_event",
        kind * 8 + int'(val), it.kind * 8 + int'(it.val));
    if (kind == K_WORD || kind == K_PAR) handed++;
    if (kind == K_DONE) chk(cyc == exp_done_cyc, "done_cycle", cyc, exp_done_cyc);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (reset || !mon_en) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk)
        chk(pkt_valid == hold_pv && data_out == hold_do, "stall_hold",
            int'({pkt_valid, data_out}), int'({hold_pv, hold_do}));
      if (!active)
        chk(pkt_valid == 1'b0 && data_out == 3'd0, "idle_out", int'({pkt_valid, data_out}), 0);
      if (active && !done && !busy) observe(pkt_valid ? K_WORD : K_PAR, data_out);
      if (done) observe(K_DONE, 3'd0);
      if (reject) observe(K_REJ, 3'd0);
      hold_chk = active && !done && busy;
      hold_pv  = pkt_valid;
      hold_do  = data_out;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_words(input vec_t v);
    for (int i = 0; i < v.n_wr; i++) begin
      wr_en = 1'b1;
      wr_data = v.w[i];
      tick();
      if (mbuf.size() < 16) mbuf.push_back(v.w[i]);
      chk(word_cnt == 5'(mbuf.size()), "wr_cnt", int'(word_cnt), mbuf.size());
      chk(wr_full == (mbuf.size() == 16), "wr_full", int'(wr_full), int'(mbuf.size() == 16));
    end
    wr_en = 1'b0;
  endtask

  task automatic do_send(input vec_t v);
    logic [2:0] hdr;
    logic [2:0] par;
    item_t it;
    hdr = {1'b0, v.dest};
    wr_en   = v.wr_with_send;
    wr_data = 3'd7;
    send    = 1'b1;
    dest    = v.dest;
    handed  = 0;
    if (v.exp_rej) begin
      it.kind = K_REJ; it.val = 3'd0; sb.push_back(it);
    end else begin
      par = hdr;
      it.kind = K_WORD; it.val = hdr; sb.push_back(it);
      foreach (mbuf[i]) begin
        it.kind = K_WORD; it.val = mbuf[i]; sb.push_back(it);
        par = par ^ mbuf[i];
      end
      it.kind = K_PAR;
      it.val  = (v.exp_par >= 0) ? v.exp_par[2:0] : par;
      sb.push_back(it);
      it.kind = K_DONE; it.val = 3'd0; sb.push_back(it);
      exp_done_cyc = cyc + 3 + mbuf.size() + v.stall_len;
    end
    tick();
    send  = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic drain(input vec_t v);
    int  stall_rem;
    bit  poked;
    int  exp_len;
    stall_rem = v.stall_len;
    poked     = 1'b0;
    exp_len   = mbuf.size();
    for (int c = 0; c < 300 && sb.size() > 0; c++) begin
      busy  = (handed == v.stall_at) && (stall_rem > 0);
      if (busy) stall_rem--;
      wr_en = 1'b0;
      send  = 1'b0;
      if (v.poke && !poked && handed == 2) begin
        wr_en = 1'b1; send = 1'b1; dest = 2'd3; wr_data = 3'd7; poked = 1'b1;
        tick();
        wr_en = 1'b0; send = 1'b0;
        chk(word_cnt == 5'(exp_len), "poke_cnt", int'(word_cnt), exp_len);
      end else begin
        tick();
      end
    end
    busy = 1'b0;
    chk(sb.size() == 0, "drain", sb.size(), 0);
    sb.delete();
    if (v.exp_rej) begin
      chk(word_cnt == 5'(mbuf.size()), "rej_cnt", int'(word_cnt), mbuf.size());
    end else begin
      mbuf.delete();
      chk(word_cnt == 5'd0, "cnt_after_done", int'(word_cnt), 0);
      chk(wr_full == 1'b0, "full_after_done", int'(wr_full), 0);
    end
  endtask

  task automatic run_pkt(input vec_t v);
    write_words(v);
    do_send(v);
    drain(v);
    tick();
  endtask

  function automatic vec_t mk(input int n_wr, input logic [1:0] d, input int stall_at,
                              input int stall_len, input bit poke, input bit wws,
                              input int exp_par, input bit exp_rej);
    vec_t v;
    v.n_wr = n_wr;
    for (int i = 0; i < 17; i++) v.w[i] = 3'((i * 5 + 3) % 8);
    v.dest = d; v.stall_at = stall_at; v.stall_len = stall_len;
    v.poke = poke; v.wr_with_send = wws; v.exp_par = exp_par; v.exp_rej = exp_rej;
    return v;
  endfunction

  vec_t rows [8];

  initial begin
    vec_t rv;
    reset = 1'b1; wr_en = 1'b0; wr_data = 3'd0; send = 1'b0; dest = 2'd0; busy = 1'b0;

    //        n_wr dest stall_at len poke wws exp_par rej
    rows[0] = mk(3,  2'd1, -1, 0, 0, 0,  1, 0);  // basic 3,5,6
    rows[1] = mk(3,  2'd1,  2, 2, 0, 0,  1, 0);  // stall on 2nd payload word
    rows[2] = mk(17, 2'd2, -1, 0, 0, 0, -1, 0);  // full buffer, 17th dropped
    rows[3] = mk(0,  2'd0, -1, 0, 0, 0, -1, 1);  // empty buffer reject
    rows[4] = mk(2,  2'd3, -1, 0, 0, 0, -1, 1);  // dest 3 reject, 2 kept
    rows[5] = mk(0,  2'd0, -1, 0, 0, 0, -1, 0);  // sends the 2 kept words
    rows[6] = mk(1,  2'd1, -1, 0, 0, 1, -1, 0);  // wr_en with send
    rows[7] = mk(4,  2'd2,  5, 1, 1, 0, -1, 0);  // pokes + parity stall
    for (int r = 0; r < 2; r++) begin
      rows[r].w[0] = 3'd3; rows[r].w[1] = 3'd5; rows[r].w[2] = 3'd6;
    end

    #12;
    chk(pkt_valid == 1'b0, "rst_pkt_valid", int'(pkt_valid), 0);
    chk(data_out == 3'd0, "rst_data_out", int'(data_out), 0);
    chk(active == 1'b0, "rst_active", int'(active), 0);
    chk(wr_full == 1'b0, "rst_wr_full", int'(wr_full), 0);
    chk(word_cnt == 5'd0, "rst_word_cnt", int'(word_cnt), 0);
    chk(done == 1'b0, "rst_done", int'(done), 0);
    chk(reject == 1'b0, "rst_reject", int'(reject), 0);
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    for (int r = 0; r < 8; r++) run_pkt(rows[r]);

    // Reset in the middle of payload word 2.
    write_words(rows[0]);
    do_send(rows[0]);
    for (int c = 0; c < 50 && handed < 2; c++) tick();
    chk(handed == 2, "reach_payload2", handed, 2);
    #3 reset = 1'b1;
    #1;
    chk(pkt_valid == 1'b0 && data_out == 3'd0, "rst_mid_out", int'({pkt_valid, data_out}), 0);
    chk(active == 1'b0 && done == 1'b0, "rst_mid_state", int'({active, done}), 0);
    chk(word_cnt == 5'd0, "rst_mid_cnt", int'(word_cnt), 0);
    sb.delete();
    mbuf.delete();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk(word_cnt == 5'd0, "post_rst_cnt", int'(word_cnt), 0);
    run_pkt(rows[0]);

    // A few random packets with random stalls.
    for (int k = 0; k < 4; k++) begin
      rv = mk($urandom_range(1, 16), 2'($urandom_range(0, 2)), 0, 0, 0, 0, -1, 0);
      for (int i = 0; i < 17; i++) rv.w[i] = 3'($urandom_range(0, 7));
      rv.stall_at  = $urandom_range(0, rv.n_wr + 1);
      rv.stall_len = $urandom_range(0, 3);
      run_pkt(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
